// File: rtl/weight_queue.sv
// Multi-lane weight queue: lanes share one head/tail/count and move together.
// Reads either consume entries in FIFO order or replay the stored window cyclically.
module weight_queue #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wq_wr_valid_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   wq_wr_data_in,
  output logic                           wq_wr_ready_out,
  input  logic                           wq_rd_req_in,
  input  logic                           wq_mode_in,
  input  logic                           wq_clear_in,
  output logic                           wq_rd_valid_out,
  output logic [NUM_CH*DATA_WIDTH-1:0]   wq_rd_data_out,
  output logic [$clog2(DEPTH+1)-1:0]     wq_count_out,
  output logic                           wq_full_out,
  output logic                           wq_empty_out,
  output logic [1:0]                     wq_err_out
);

  localparam int unsigned BEAT_W = NUM_CH * DATA_WIDTH;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W  = PTR_W + 1;

  logic [BEAT_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  head, head_nxt;
  logic [PTR_W-1:0]  tail, tail_nxt;
  logic [PTR_W-1:0]  roff, roff_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              rd_valid, rd_valid_nxt;
  logic [BEAT_W-1:0] rd_data, rd_data_nxt;
  logic [1:0]        err, err_nxt;

  logic              full, empty;
  logic              wr_acc, rd_acc, pop;
  logic [PTR_W-1:0]  head_inc, tail_inc, rd_idx;
  logic [SUM_W-1:0]  replay_sum;

  // Status flags come straight from the registered count.
  assign full            = (count == CNT_W'(DEPTH));
  assign empty           = (count == CNT_W'(0));
  assign wq_full_out     = full;
  assign wq_empty_out    = empty;
  assign wq_wr_ready_out = !full;
  assign wq_count_out    = count;
  assign wq_rd_valid_out = rd_valid;
  assign wq_rd_data_out  = rd_data;
  assign wq_err_out      = err;

  assign wr_acc = wq_wr_valid_in && !full;
  assign rd_acc = wq_rd_req_in && !empty;
  assign pop    = rd_acc && !wq_mode_in;

  assign head_inc = (head == PTR_W'(DEPTH - 1)) ? '0 : head + PTR_W'(1);
  assign tail_inc = (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + PTR_W'(1);

  // Replay address is head + roff folded back into [0, DEPTH).
  always_comb begin
    replay_sum = {1'b0, head} + {1'b0, roff};
    if (replay_sum >= SUM_W'(DEPTH)) begin
      rd_idx = PTR_W'(replay_sum - SUM_W'(DEPTH));
    end else begin
      rd_idx = PTR_W'(replay_sum);
    end
    if (!wq_mode_in) begin
      rd_idx = head;
    end
  end

  // Next-state for all control registers; clear overrides everything.
  always_comb begin
    head_nxt     = head;
    tail_nxt     = tail;
    roff_nxt     = roff;
    count_nxt    = count;
    rd_valid_nxt = 1'b0;
    rd_data_nxt  = rd_data;
    err_nxt      = err;

    if (wq_clear_in) begin
      head_nxt    = '0;
      tail_nxt    = '0;
      roff_nxt    = '0;
      count_nxt   = '0;
      rd_data_nxt = '0;
      err_nxt     = '0;
    end else begin
      if (wr_acc) begin
        tail_nxt = tail_inc;
      end
      if (wq_wr_valid_in && full) begin
        err_nxt[0] = 1'b1;
      end
      if (wq_rd_req_in && empty) begin
        err_nxt[1] = 1'b1;
      end
      if (rd_acc) begin
        rd_valid_nxt = 1'b1;
        rd_data_nxt  = mem[rd_idx];
      end

      if (!wq_mode_in) begin
        roff_nxt = '0;
        if (rd_acc) begin
          head_nxt = head_inc;
        end
      end else if (rd_acc) begin
        roff_nxt = (CNT_W'(roff) + CNT_W'(1) >= count) ? '0 : roff + PTR_W'(1);
      end

      case ({wr_acc, pop})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      roff     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      err      <= '0;
    end else begin
      head     <= head_nxt;
      tail     <= tail_nxt;
      roff     <= roff_nxt;
      count    <= count_nxt;
      rd_valid <= rd_valid_nxt;
      rd_data  <= rd_data_nxt;
      err      <= err_nxt;
    end
  end

  // Storage is never reset; reads are gated by count so stale data is never exposed.
  always_ff @(posedge clk) begin
    if (wr_acc && !wq_clear_in) begin
      mem[tail] <= wq_wr_data_in;
    end
  end

endmodule

// File: tb/tb_weight_queue.sv
// Self-checking bench for weight_queue (DATA_WIDTH=16, NUM_CH=2, DEPTH=4):
// vector table plus hand sequences, with read data verified through a scoreboard queue.
module tb_weight_queue;

  logic        clk;
  logic        rst;
  logic        wq_wr_valid_in;
  logic [31:0] wq_wr_data_in;
  logic        wq_wr_ready_out;
  logic        wq_rd_req_in;
  logic        wq_mode_in;
  logic        wq_clear_in;
  logic        wq_rd_valid_out;
  logic [31:0] wq_rd_data_out;
  logic [2:0]  wq_count_out;
  logic        wq_full_out;
  logic        wq_empty_out;
  logic [1:0]  wq_err_out;

  weight_queue #(.DATA_WIDTH(16), .NUM_CH(2), .DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .wq_wr_valid_in  (wq_wr_valid_in),
    .wq_wr_data_in   (wq_wr_data_in),
    .wq_wr_ready_out (wq_wr_ready_out),
    .wq_rd_req_in    (wq_rd_req_in),
    .wq_mode_in      (wq_mode_in),
    .wq_clear_in     (wq_clear_in),
    .wq_rd_valid_out (wq_rd_valid_out),
    .wq_rd_data_out  (wq_rd_data_out),
    .wq_count_out    (wq_count_out),
    .wq_full_out     (wq_full_out),
    .wq_empty_out    (wq_empty_out),
    .wq_err_out      (wq_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] wdata;
    logic        rd;
    logic        mode;
    logic        clr;
    logic        ev;
    logic [31:0] ed;
    int          ec;
    logic [1:0]  ee;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [31:0] wdata, input logic rd, input logic mode,
                     input logic clr, input logic ev, input logic [31:0] ed, input int ec,
                     input logic [1:0] ee);
    vec_t v;
    v.wr = wr; v.wdata = wdata; v.rd = rd; v.mode = mode; v.clr = clr;
    v.ev = ev; v.ed = ed; v.ec = ec; v.ee = ee;
    vecs.push_back(v);
  endtask

  // Returned beats are matched in order against what the bench expected to be read.
  task automatic sb_pop(input string tag);
    logic [31:0] exp;
    if (wq_rd_valid_out) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s sb: got unexpected beat %h expected none", tag, wq_rd_data_out);
      end else begin
        exp = sb.pop_front();
        check({tag, " sb"}, wq_rd_data_out, exp);
      end
    end
  endtask

  task automatic step(input string tag, input logic wr, input logic [31:0] d, input logic rd,
                      input logic mode, input logic clr, input logic exp_acc,
                      input logic [31:0] exp_rd);
    wq_wr_valid_in = wr;
    wq_wr_data_in  = d;
    wq_rd_req_in   = rd;
    wq_mode_in     = mode;
    wq_clear_in    = clr;
    if (exp_acc) sb.push_back(exp_rd);
    @(posedge clk);
    #1;
    wq_wr_valid_in = 1'b0;
    wq_rd_req_in   = 1'b0;
    wq_mode_in     = 1'b0;
    wq_clear_in    = 1'b0;
    sb_pop(tag);
  endtask

  task automatic check_state(input string tag, input logic ev, input int ec, input logic [1:0] ee);
    check({tag, " valid"}, 32'(wq_rd_valid_out), 32'(ev));
    check({tag, " count"}, 32'(wq_count_out), 32'(ec));
    check({tag, " err"},   32'(wq_err_out), 32'(ee));
    check({tag, " full"},  32'(wq_full_out), 32'(ec == 4));
    check({tag, " empty"}, 32'(wq_empty_out), 32'(ec == 0));
    check({tag, " ready"}, 32'(wq_wr_ready_out), 32'(ec != 4));
  endtask

  task automatic check_reset(input string tag);
    check({tag, " data"}, wq_rd_data_out, 32'h0);
    check_state(tag, 1'b0, 0, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    wq_wr_valid_in = 1'b0;
    wq_wr_data_in  = '0;
    wq_rd_req_in   = 1'b0;
    wq_mode_in     = 1'b0;
    wq_clear_in    = 1'b0;

    // In-order consume of two beats
    add(1, 32'h0002_0001, 0, 0, 0, 0, 32'h0, 1, 2'b00);
    add(1, 32'h0004_0003, 0, 0, 0, 0, 32'h0, 2, 2'b00);
    add(0, 32'h0, 1, 0, 0, 1, 32'h0002_0001, 1, 2'b00);
    add(0, 32'h0, 1, 0, 0, 1, 32'h0004_0003, 0, 2'b00);
    add(0, 32'h0, 0, 0, 0, 0, 32'h0004_0003, 0, 2'b00);
    // Overflow: fifth beat dropped
    add(1, 32'h1111_1111, 0, 0, 0, 0, 32'h0004_0003, 1, 2'b00);
    add(1, 32'h2222_2222, 0, 0, 0, 0, 32'h0004_0003, 2, 2'b00);
    add(1, 32'h3333_3333, 0, 0, 0, 0, 32'h0004_0003, 3, 2'b00);
    add(1, 32'h4444_4444, 0, 0, 0, 0, 32'h0004_0003, 4, 2'b00);
    add(1, 32'h5555_5555, 0, 0, 0, 0, 32'h0004_0003, 4, 2'b01);
    add(0, 32'h0, 1, 0, 0, 1, 32'h1111_1111, 3, 2'b01);
    add(0, 32'h0, 1, 0, 0, 1, 32'h2222_2222, 2, 2'b01);
    add(0, 32'h0, 1, 0, 0, 1, 32'h3333_3333, 1, 2'b01);
    add(0, 32'h0, 1, 0, 0, 1, 32'h4444_4444, 0, 2'b01);
    add(0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 2'b00);
    // Replay A,B,C cyclically, then consume A
    add(1, 32'h0000_000A, 0, 0, 0, 0, 32'h0, 1, 2'b00);
    add(1, 32'h0000_000B, 0, 0, 0, 0, 32'h0, 2, 2'b00);
    add(1, 32'h0000_000C, 0, 0, 0, 0, 32'h0, 3, 2'b00);
    add(0, 32'h0, 1, 1, 0, 1, 32'h0000_000A, 3, 2'b00);
    add(0, 32'h0, 1, 1, 0, 1, 32'h0000_000B, 3, 2'b00);
    add(0, 32'h0, 1, 1, 0, 1, 32'h0000_000C, 3, 2'b00);
    add(0, 32'h0, 1, 1, 0, 1, 32'h0000_000A, 3, 2'b00);
    add(0, 32'h0, 1, 1, 0, 1, 32'h0000_000B, 3, 2'b00);
    add(0, 32'h0, 1, 1, 0, 1, 32'h0000_000C, 3, 2'b00);
    add(0, 32'h0, 1, 1, 0, 1, 32'h0000_000A, 3, 2'b00);
    add(0, 32'h0, 1, 0, 0, 1, 32'h0000_000A, 2, 2'b00);
    // Underflow and clear
    add(0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 2'b00);
    add(0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 2'b10);
    add(1, 32'h0000_0077, 0, 0, 0, 0, 32'h0, 1, 2'b10);
    add(1, 32'h0000_0088, 0, 0, 0, 0, 32'h0, 2, 2'b10);
    add(0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 2'b00);
    add(0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 2'b10);
    add(0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 2'b00);
    // Replay with a concurrent write grows count
    add(1, 32'h0001_0001, 0, 0, 0, 0, 32'h0, 1, 2'b00);
    add(1, 32'h0002_0002, 0, 0, 0, 0, 32'h0, 2, 2'b00);
    add(1, 32'h0003_0003, 1, 1, 0, 1, 32'h0001_0001, 3, 2'b00);
    add(0, 32'h0, 1, 1, 0, 1, 32'h0002_0002, 3, 2'b00);
    add(0, 32'h0, 1, 1, 0, 1, 32'h0003_0003, 3, 2'b00);
    add(0, 32'h0, 1, 1, 0, 1, 32'h0001_0001, 3, 2'b00);
    add(0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 2'b00);

    // Reset must take effect without a clock edge
    #2;
    check_reset("reset_async");
    @(posedge clk);
    #1;
    check_reset("reset_held");
    rst = 1'b1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tag, vecs[i].wr, vecs[i].wdata, vecs[i].rd, vecs[i].mode, vecs[i].clr,
           vecs[i].ev, vecs[i].ed);
      check({tag, " data"}, wq_rd_data_out, vecs[i].ed);
      check_state(tag, vecs[i].ev, vecs[i].ec, vecs[i].ee);
    end

    // Full queue: write + consume in the same cycle rejects the write
    for (int i = 0; i < 4; i++) step("fill", 1, 32'hD000_0000 + 32'(i), 0, 0, 0, 0, 32'h0);
    check_state("fill", 1'b0, 4, 2'b00);
    step("full_wr_rd", 1, 32'hBAD0_BAD0, 1, 0, 0, 1, 32'hD000_0000);
    check_state("full_wr_rd", 1'b1, 3, 2'b01);
    step("drop1", 0, 32'h0, 1, 0, 0, 1, 32'hD000_0001);
    check_state("drop1", 1'b1, 2, 2'b01);
    step("mid_wr_rd", 1, 32'h0000_5A5A, 1, 0, 0, 1, 32'hD000_0002);
    check_state("mid_wr_rd", 1'b1, 2, 2'b01);
    step("drain1", 0, 32'h0, 1, 0, 0, 1, 32'hD000_0003);
    step("drain2", 0, 32'h0, 1, 0, 0, 1, 32'h0000_5A5A);
    check_state("drain2", 1'b1, 0, 2'b01);
    step("clr2", 0, 32'h0, 0, 0, 1, 0, 32'h0);

    // Reset asserted between edges with three entries held
    for (int i = 0; i < 4; i++) step("rfill", 1, 32'hE000_0000 + 32'(i), 0, 0, 0, 0, 32'h0);
    step("rovf", 1, 32'hE000_0004, 0, 0, 0, 0, 32'h0);
    step("rpop", 0, 32'h0, 1, 0, 0, 1, 32'hE000_0000);
    check({"rpop", " data"}, wq_rd_data_out, 32'hE000_0000);
    check_state("rpop", 1'b1, 3, 2'b01);
    #2;
    rst = 1'b0;
    #1;
    check_reset("reset_mid");
    wq_wr_valid_in = 1'b1;
    wq_wr_data_in  = 32'hFEED_FEED;
    wq_rd_req_in   = 1'b1;
    @(posedge clk);
    #1;
    check_reset("reset_abort");
    sb.delete();
    rst = 1'b1;
    step("post_wr", 1, 32'h0000_0C0C, 0, 0, 0, 0, 32'h0);
    check_state("post_wr", 1'b0, 1, 2'b00);
    step("post_rd", 0, 32'h0, 1, 0, 0, 1, 32'h0000_0C0C);
    check({"post_rd", " data"}, wq_rd_data_out, 32'h0000_0C0C);
    check_state("post_rd", 1'b1, 0, 2'b00);

    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weight_queue.md
WEIGHT_QUEUE -- requirements
Module: weight_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed bit width of one weight.
REQ-002 SHALL have parameter NUM_CH, default 2, number of weight lanes moved per beat.
REQ-003 SHALL have parameter DEPTH, default 4, entries per lane; legal range DEPTH >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wq_wr_valid_in  input  1  write beat present.
REQ-007 SHALL have port wq_wr_data_in  input  NUM_CH*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port wq_wr_ready_out  output  1  equals !wq_full_out, combinational from registered state.
REQ-009 SHALL have port wq_rd_req_in  input  1  read beat requested.
REQ-010 SHALL have port wq_mode_in  input  1  0 = consume (FIFO pop), 1 = replay (non-destructive cyclic read).
REQ-011 SHALL have port wq_clear_in  input  1  synchronous flush.
REQ-012 SHALL have port wq_rd_valid_out  output  1  registered; wq_rd_data_out holds a valid beat.
REQ-013 SHALL have port wq_rd_data_out  output  NUM_CH*DATA_WIDTH  registered read beat, same lane packing as REQ-007.
REQ-014 SHALL have ports wq_count_out  output  $clog2(DEPTH+1)  stored entries; wq_full_out and wq_empty_out  output  1 each.
REQ-015 SHALL have port wq_err_out  output  2  sticky; bit0 = overflow, bit1 = underflow.

Function
REQ-016 All lanes SHALL share a single head pointer, a single tail pointer and a single count; each accepted beat writes every lane at the tail.
REQ-017 A write SHALL be accepted iff wq_wr_valid_in && !wq_full_out; on acceptance the tail advances, wrapping from DEPTH-1 to 0.
REQ-018 A write attempted while full SHALL be dropped, leave storage unchanged and set wq_err_out[0].
REQ-019 A read SHALL be accepted iff wq_rd_req_in && !wq_empty_out; next cycle wq_rd_valid_out = 1 and wq_rd_data_out = the selected entry (latency 1).
REQ-020 A read request while empty SHALL set wq_err_out[1] and give wq_rd_valid_out = 0 next cycle; there is no write-to-read bypass.
REQ-021 When no read is accepted, wq_rd_valid_out SHALL go to 0 and wq_rd_data_out SHALL hold its previous value.
REQ-022 In mode 0, an accepted read SHALL return the entry at head, advance head with wrap, and decrement count.
REQ-023 In mode 1, an accepted read SHALL return the entry at head+roff (mod DEPTH), where roff is a replay offset register.
REQ-024 In mode 1, roff SHALL increment after each accepted read and return to 0 after the read at roff = count-1; head and count stay unchanged.
REQ-025 roff SHALL be reset to 0 on any cycle where wq_mode_in = 0, and in the cycle following any consume read.
REQ-026 A simultaneous accepted write and accepted read SHALL leave count unchanged in mode 0 and increase count by 1 in mode 1.
REQ-027 Full and empty SHALL be evaluated on pre-edge state; a write while full SHALL NOT be accepted even if a consume read occurs in the same cycle.
REQ-028 wq_full_out SHALL equal (count == DEPTH) and wq_empty_out SHALL equal (count == 0), both derived from registered count.
REQ-029 wq_clear_in SHALL have priority over all other inputs in its cycle and SHALL return every register to its reset value at the next edge.
REQ-030 Storage contents SHALL be undefined after clear or reset; behaviour SHALL never expose them, because reads are gated by count.

Reset
REQ-031 Reset assertion (rst = 0) SHALL immediately force the following, with no clock required: head = tail = roff = count = 0, wq_rd_valid_out = 0, wq_rd_data_out = 0, wq_err_out = 0, wq_empty_out = 1, wq_full_out = 0, wq_wr_ready_out = 1.
REQ-032 Reset asserted mid-transfer SHALL abort that transfer; the first operation SHALL be accepted at the first rising edge after rst deasserts.

Verification (DATA_WIDTH=16, NUM_CH=2, DEPTH=4)
REQ-033 Write {0x0002,0x0001}, {0x0004,0x0003}, then issue 2 reads in mode 0 -> data out in order, each 1 cycle after its request; count goes 2->1->0; empty = 1.
REQ-034 Write 4 beats, then write a 5th -> full = 1, ready = 0, err[0] = 1, 5th beat absent from the subsequent 4 reads.
REQ-035 Hold 3 entries A,B,C, mode 1, issue 7 reads -> outputs A,B,C,A,B,C,A; count stays 3; mode 0 read then returns A.
REQ-036 Full queue, write and mode-0 read in the same cycle -> write rejected, err[0] = 1, count = 3; at count = 2, the same pair -> count stays 2.
REQ-037 Read on empty -> err[1] = 1, rd_valid stays 0; 2 entries plus clear -> count = 0, err = 0, next read is an underflow.
REQ-038 Drive rst low between edges with count = 3 -> outputs take their reset values before the next edge; a write after deassert lands at index 0.
